// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the NMC write-back path: FSM encoding and default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_ctrl_pkg;

  // Geometry defaults shared with the NMC array so both ends agree on vector shape
  localparam int DEF_RELU_OUT_PRECISION = 4;
  localparam int DEF_DIM                = 64;
  localparam int DEF_ADDR_W             = 6;
  localparam int DEF_FIFO_DEPTH         = 4;

  // Write-back job sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// First-word fall-through FIFO holding activation vectors awaiting write-back.
// Latency: entry pushed in cycle N is visible on o_head_dat in cycle N+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  // DEPTH is a power of two, so pointers wrap naturally at AW bits
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   C_CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full     = (r_cnt == C_CNT_FULL);
  assign o_empty    = (r_cnt == '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_pop_ok   = i_pop && !o_empty;
  // A pop frees the slot the push needs, so full+pop+push is legal
  assign w_push_ok  = i_push && (!o_full || w_pop_ok);

  // Storage: cleared on reset so the head reads zero while empty after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + C_CNT_ONE;
        2'b01:   r_cnt <= r_cnt - C_CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: buffers NMC ReLU vectors and writes them to consecutive memory rows.
// Latency: vector accepted in cycle N into an empty buffer is offered on wb_* in cycle N+1.
// Backpressure: wb_ready stalls the head; a vector arriving with the buffer full is dropped and flagged.
module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int RELU_OUT_PRECISION = DEF_RELU_OUT_PRECISION,
  parameter int DIM                = DEF_DIM,
  parameter int ADDR_W             = DEF_ADDR_W,
  parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [ADDR_W:0]                  num_rows,
  input  logic                             relu_valid,
  input  logic [RELU_OUT_PRECISION*DIM-1:0] relu_out,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [ADDR_W-1:0]                wb_addr,
  output logic [RELU_OUT_PRECISION*DIM-1:0] wb_data,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);

  localparam int W = RELU_OUT_PRECISION * DIM;
  localparam logic [ADDR_W:0]   C_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);

  wb_state_e         r_state;
  wb_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0]   r_acc_cnt;
  logic [ADDR_W:0]   r_wr_cnt;
  logic              r_overflow;

  logic              w_start_ok;
  logic              w_offer;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [W-1:0]      w_head;

  // Start only counts in IDLE; a start during a job is ignored
  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_pop      = !w_fifo_empty && wb_ready;
  // Vectors beyond the job size or outside RUN are silently ignored
  assign w_offer    = (r_state == ST_RUN) && relu_valid && (r_acc_cnt != '0);
  assign w_push     = w_offer && (!w_fifo_full || w_pop);
  assign w_drop     = w_offer && w_fifo_full && !w_pop;

  assign wb_valid = !w_fifo_empty;
  assign wb_data  = w_head;
  assign wb_addr  = r_wr_addr;
  assign overflow = r_overflow;

  wb_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (relu_out),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: RUN ends after the handshake that writes the last row
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = (num_rows == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_pop && (r_wr_cnt == C_CNT_ONE)) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy only while a job runs, done is the single DONE cycle
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Job counters, row pointer and sticky drop flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr  <= '0;
      r_acc_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_wr_addr  <= base_addr;
      r_acc_cnt  <= num_rows;
      r_wr_cnt   <= num_rows;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_acc_cnt <= r_acc_cnt - C_CNT_ONE;
      if (w_pop) begin
        r_wr_addr <= r_wr_addr + C_ADDR_ONE;
        if (r_wr_cnt != '0) r_wr_cnt <= r_wr_cnt - C_CNT_ONE;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
module tb_wb_ctrl;
  localparam int P  = 4;
  localparam int D  = 64;
  localparam int AW = 6;
  localparam int FD = 4;
  localparam int W  = P * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_rows = '0;
  logic          relu_valid = 1'b0;
  logic [W-1:0]  relu_out = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          busy, done, overflow;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [AW-1:0] addr; logic [W-1:0] data; } wr_t;
  wr_t sb[$];
  wr_t exp_w;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   rows;
    int            nvec;
    logic          exp_ovf;
    logic [AW-1:0] exp_end;
  } job_t;
  job_t jobs[5];

  wb_ctrl #(.RELU_OUT_PRECISION(P), .DIM(D), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .relu_valid(relu_valid), .relu_out(relu_out), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_data(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW:0] r);
    start = 1'b1; base_addr = b; num_rows = r;
    cyc();
    start = 1'b0;
  endtask

  // Drive n vectors back-to-back; the first lim are expected to be written from addr a0 on
  task automatic drive_vecs(input int n, input int lim, input logic [AW-1:0] a0);
    logic [W-1:0] v;
    wr_t e;
    for (int i = 0; i < n; i++) begin
      v = rand_vec();
      relu_out = v;
      relu_valid = 1'b1;
      if (i < lim) begin
        e.addr = AW'(int'(a0) + i);
        e.data = v;
        sb.push_back(e);
      end
      cyc();
    end
    relu_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    logic prev_busy;
    bit   seen;
    seen = 1'b0;
    prev_busy = busy;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, "_busy_before_done"}, 64'(prev_busy), 64'd1);
        cyc();
        chk({nm, "_done_single_pulse"}, 64'(done), 64'd0);
      end else begin
        prev_busy = busy;
        cyc();
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done got 0 expected 1 within 100 cycles", nm);
    end
  endtask

  initial begin
    string nm;
    // Write monitor: a handshake seen mid-cycle completes at the next rising edge
    fork
      forever begin
        @(negedge clk);
        if (rst_n && wb_valid && wb_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr %0h expected no write", wb_addr);
          end else begin
            exp_w = sb.pop_front();
            if (wb_addr !== exp_w.addr || wb_data !== exp_w.data) begin
              errors++;
              $display("FAIL write_order: got addr %0h data %h expected addr %0h data %h",
                       wb_addr, wb_data, exp_w.addr, exp_w.data);
            end
          end
        end
      end
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk_data("rst_wb_data", wb_data, '0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Table of simple jobs with wb_ready held high
    jobs[0] = '{base: 6'd5,  rows: 7'd3, nvec: 3, exp_ovf: 1'b0, exp_end: 6'd8};
    jobs[1] = '{base: 6'd62, rows: 7'd4, nvec: 4, exp_ovf: 1'b0, exp_end: 6'd2};
    jobs[2] = '{base: 6'd63, rows: 7'd2, nvec: 4, exp_ovf: 1'b0, exp_end: 6'd1};
    jobs[3] = '{base: 6'd10, rows: 7'd0, nvec: 0, exp_ovf: 1'b0, exp_end: 6'd10};
    jobs[4] = '{base: 6'd0,  rows: 7'd1, nvec: 1, exp_ovf: 1'b0, exp_end: 6'd1};
    wb_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      nm = $sformatf("job%0d", j);
      start_job(jobs[j].base, jobs[j].rows);
      if (jobs[j].rows == '0) begin
        chk({nm, "_zero_done"}, 64'(done), 64'd1);
        chk({nm, "_zero_busy"}, 64'(busy), 64'd0);
        chk({nm, "_zero_wb_valid"}, 64'(wb_valid), 64'd0);
        cyc();
        chk({nm, "_zero_done_single"}, 64'(done), 64'd0);
        chk({nm, "_zero_wb_valid_after"}, 64'(wb_valid), 64'd0);
      end else begin
        fork
          drive_vecs(jobs[j].nvec, int'(jobs[j].rows), jobs[j].base);
          wait_done(nm);
        join
      end
      chk({nm, "_overflow"}, 64'(overflow), 64'(jobs[j].exp_ovf));
      chk({nm, "_end_addr"}, 64'(wb_addr), 64'(jobs[j].exp_end));
      chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
      chk({nm, "_wb_valid_idle"}, 64'(wb_valid), 64'd0);
    end

    // Overflow: stalled memory, 5 vectors into a 4-deep buffer
    wb_ready = 1'b0;
    start_job(6'd20, 7'd8);
    chk("ovf_no_valid_yet", 64'(wb_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] v;
      wr_t e;
      v = rand_vec();
      relu_out = v;
      relu_valid = 1'b1;
      if (i < 4) begin
        e.addr = AW'(20 + i);
        e.data = v;
        sb.push_back(e);
      end
      cyc();
      if (i == 0) begin
        chk("ovf_first_latency_valid", 64'(wb_valid), 64'd1);
        chk_data("ovf_first_latency_data", wb_data, v);
      end
    end
    relu_valid = 1'b0;
    chk("ovf_flag_set", 64'(overflow), 64'd1);
    chk("ovf_head_addr", 64'(wb_addr), 64'd20);
    chk_data("ovf_head_data", wb_data, sb[0].data);
    chk("ovf_busy", 64'(busy), 64'd1);
    // A start during RUN must not reload the job or clear the flag
    start = 1'b1; base_addr = 6'd0; num_rows = 7'd1;
    cyc();
    start = 1'b0;
    repeat (2) cyc();
    chk("ovf_start_ignored_addr", 64'(wb_addr), 64'd20);
    chk("ovf_start_ignored_flag", 64'(overflow), 64'd1);
    chk_data("ovf_data_held", wb_data, sb[0].data);
    chk("ovf_still_busy", 64'(busy), 64'd1);
    wb_ready = 1'b1;
    repeat (5) cyc();
    chk("ovf_drained", 64'(sb.size()), 64'd0);
    chk("ovf_drained_valid", 64'(wb_valid), 64'd0);
    chk("ovf_drained_addr", 64'(wb_addr), 64'd24);
    // The drop did not consume a slot: four more vectors complete the job
    fork
      drive_vecs(4, 4, 6'd24);
      wait_done("ovf_job");
    join
    chk("ovf_sticky_after_done", 64'(overflow), 64'd1);
    chk("ovf_end_addr", 64'(wb_addr), 64'd28);

    // Full buffer with simultaneous pop and push: no drop
    wb_ready = 1'b0;
    start_job(6'd30, 7'd6);
    chk("full_overflow_cleared", 64'(overflow), 64'd0);
    drive_vecs(4, 4, 6'd30);
    chk("full_valid", 64'(wb_valid), 64'd1);
    wb_ready = 1'b1;
    fork
      drive_vecs(2, 2, 6'd34);
      wait_done("full_job");
    join
    chk("full_no_overflow", 64'(overflow), 64'd0);
    chk("full_end_addr", 64'(wb_addr), 64'd36);
    chk("full_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-job discards buffered vectors
    wb_ready = 1'b0;
    start_job(6'd40, 7'd4);
    drive_vecs(2, 0, 6'd40);
    chk("mid_rst_pre_valid", 64'(wb_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(wb_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(wb_addr), 64'd0);
    chk_data("mid_rst_data", wb_data, '0);
    wb_ready = 1'b1;
    relu_out = rand_vec();
    relu_valid = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("post_rst_no_write%0d", i), 64'(wb_valid), 64'd0);
    end
    relu_valid = 1'b0;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_overflow", 64'(overflow), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
